// File: rtl/jtframe_pocket_upload_if.sv
// rtl/jtframe_pocket_upload_if.sv - bridge read-request bundle for the Pocket upload path
//
// Purpose: groups the bridge-side read request and its response so the
// requester (master) and the upload engine (slave) share one port.
// Signals:
//   bridge_rd       master->slave  single-cycle read request
//   bridge_addr     master->slave  32-bit word address, bits [22:0] used
//   bridge_rd_data  slave->master  assembled word, held until the next rd_valid
//   rd_valid        slave->master  one-cycle pulse, bridge_rd_data valid
//   rd_busy         slave->master  demand fetch in progress
interface jtframe_pocket_upload_if;
  logic        bridge_rd;
  logic [31:0] bridge_addr;
  logic [31:0] bridge_rd_data;
  logic        rd_valid;
  logic        rd_busy;

  modport master (
    output bridge_rd, bridge_addr,
    input  bridge_rd_data, rd_valid, rd_busy
  );

  modport slave (
    input  bridge_rd, bridge_addr,
    output bridge_rd_data, rd_valid, rd_busy
  );
endinterface

// File: rtl/jtframe_pocket_upload.sv
// rtl/jtframe_pocket_upload.sv - Pocket bridge read path, four ioctl byte reads per word
//
// Purpose: answers bridge read requests by fetching four bytes from core
// memory over the ioctl byte bus and packing them little-endian (first byte
// fetched lands in [7:0]).
// Ports:
//   clk, rst_n      ROM/ioctl clock, asynchronous active-low reset
//   bridge          jtframe_pocket_upload_if.slave (request, word, rd_valid, rd_busy)
//   dataslot_done   end of host transfer: clears uploading
//   uploading       upload session active
//   ioctl_addr      byte address {word_addr[22:0], byte_index}
//   ioctl_rd        one-cycle strobe per byte
//   ioctl_din       byte returned RD_LAT cycles after the strobe
// Optional feature macro: JTFRAME_POCKET_UPLOAD_PREFETCH_EN
//   When defined, the word after each delivered word is fetched in the
//   background so a sequential read can be answered in one cycle.
module jtframe_pocket_upload #(
  parameter int RD_LAT = 2,
  parameter int AW     = 25
) (
  input  logic                   clk,
  input  logic                   rst_n,
  jtframe_pocket_upload_if.slave bridge,
  input  logic                   dataslot_done,
  output logic                   uploading,
  output logic [AW-1:0]          ioctl_addr,
  output logic                   ioctl_rd,
  input  logic [7:0]             ioctl_din
);

`ifdef JTFRAME_POCKET_UPLOAD_PREFETCH_EN
  localparam bit PF_EN = 1'b1;
`else
  localparam bit PF_EN = 1'b0;
`endif

  localparam logic [2:0] LAT_M1 = (RD_LAT == 0) ? 3'd0 : 3'(RD_LAT - 1);

  typedef enum logic [1:0] {IDLE, STROBE, WAIT, DONE} state_t;
  typedef enum logic [1:0] {OUT_HOLD, OUT_FETCH, OUT_PF} out_sel_t;

  state_t      state, state_nx;
  out_sel_t    out_sel;
  logic [22:0] addr_q, addr_nx;
  logic [1:0]  cnt, cnt_nx;
  logic [2:0]  lat, lat_nx;
  logic [23:0] shift_q;
  logic [31:0] rd_data_q;
  logic [31:0] pf_data;
  logic        pf_mode, pf_mode_nx;    // current fetch is a background prefetch
  logic        pf_valid, pf_valid_nx;  // pf_data holds word addr_q
  logic        pf_load;
  logic        sample;
  logic [22:0] req;
  logic        unused_addr_hi;

  assign req            = bridge.bridge_addr[22:0];
  assign unused_addr_hi = ^bridge.bridge_addr[31:23];

  // With zero latency the byte is already on ioctl_din during the strobe.
  assign sample = (state == STROBE && RD_LAT == 0) || (state == WAIT && lat == 3'd0);

  always_comb begin
    state_nx    = state;
    addr_nx     = addr_q;
    cnt_nx      = cnt;
    lat_nx      = lat;
    pf_mode_nx  = pf_mode;
    pf_valid_nx = pf_valid;
    out_sel     = OUT_HOLD;
    pf_load     = 1'b0;

    case (state)
      STROBE: begin
        if (RD_LAT != 0) begin
          state_nx = WAIT;
          lat_nx   = LAT_M1;
        end
      end
      WAIT: begin
        if (lat != 3'd0) lat_nx = lat - 3'd1;
      end
      DONE: begin
        state_nx = IDLE;
        if (PF_EN && !dataslot_done) begin
          state_nx    = STROBE;
          addr_nx     = addr_q + 23'd1;
          cnt_nx      = 2'd0;
          pf_mode_nx  = 1'b1;
          pf_valid_nx = 1'b0;
        end
      end
      default: ;
    endcase

    if (sample) begin
      if (cnt == 2'd3) begin
        if (pf_mode) begin
          state_nx    = IDLE;
          pf_mode_nx  = 1'b0;
          pf_load     = 1'b1;
          pf_valid_nx = 1'b1;
        end else begin
          state_nx = DONE;
          out_sel  = OUT_FETCH;
        end
      end else begin
        cnt_nx   = cnt + 2'd1;
        state_nx = STROBE;
      end
    end

    // End of the host transfer drops any background work.
    if (PF_EN && dataslot_done) begin
      pf_valid_nx = 1'b0;
      pf_load     = 1'b0;
      if (pf_mode) begin
        state_nx   = IDLE;
        pf_mode_nx = 1'b0;
      end
    end

    if (bridge.bridge_rd) begin
      if (PF_EN && !dataslot_done && state == IDLE && pf_valid && req == addr_q) begin
        state_nx    = DONE;
        out_sel     = OUT_PF;
        pf_valid_nx = 1'b0;
      end else if (PF_EN && !dataslot_done && pf_mode && req == addr_q) begin
        // Adopt the running prefetch as the demand fetch.
        pf_mode_nx = 1'b0;
        if (sample && cnt == 2'd3) begin
          state_nx    = DONE;
          out_sel     = OUT_FETCH;
          pf_load     = 1'b0;
          pf_valid_nx = 1'b0;
        end
      end else begin
        state_nx    = STROBE;
        addr_nx     = req;
        cnt_nx      = 2'd0;
        pf_mode_nx  = 1'b0;
        pf_valid_nx = 1'b0;
        pf_load     = 1'b0;
        out_sel     = OUT_HOLD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      cnt       <= '0;
      lat       <= '0;
      shift_q   <= '0;
      rd_data_q <= '0;
      pf_data   <= '0;
      pf_mode   <= 1'b0;
      pf_valid  <= 1'b0;
      uploading <= 1'b0;
    end else begin
      state    <= state_nx;
      addr_q   <= addr_nx;
      cnt      <= cnt_nx;
      lat      <= lat_nx;
      pf_mode  <= pf_mode_nx;
      pf_valid <= pf_valid_nx;
      if (sample) begin
        case (cnt)
          2'd0:    shift_q[7:0]   <= ioctl_din;
          2'd1:    shift_q[15:8]  <= ioctl_din;
          2'd2:    shift_q[23:16] <= ioctl_din;
          default: ;
        endcase
      end
      case (out_sel)
        OUT_FETCH: rd_data_q <= {ioctl_din, shift_q};
        OUT_PF:    rd_data_q <= pf_data;
        default:   ;
      endcase
      if (pf_load) pf_data <= {ioctl_din, shift_q};
      if (bridge.bridge_rd)   uploading <= 1'b1;
      else if (dataslot_done) uploading <= 1'b0;
    end
  end

  assign ioctl_rd              = (state == STROBE);
  assign ioctl_addr            = AW'({addr_q, cnt});
  assign bridge.rd_valid       = (state == DONE);
  assign bridge.rd_busy        = (state != IDLE) && !pf_mode;
  assign bridge.bridge_rd_data = rd_data_q;

endmodule

// File: tb/tb_jtframe_pocket_upload.sv
// tb/tb_jtframe_pocket_upload.sv - scoreboard bench for jtframe_pocket_upload (RD_LAT 0 and 2)
module tb_jtframe_pocket_upload;
  typedef struct packed {
    int          cyc;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ds0, ds2, upl0, upl2, ir0, ir2;
  logic [24:0] ia0, ia2;
  logic [7:0]  din0, din2;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          strobe_chk;
  exp_t        sq0[$], sq1[$], vq0[$], vq1[$];
  logic        hv[2];
  logic [24:0] ha[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  jtframe_pocket_upload_if bif0();
  jtframe_pocket_upload_if bif2();

  jtframe_pocket_upload #(.RD_LAT(0), .AW(25)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bridge(bif0), .dataslot_done(ds0), .uploading(upl0),
    .ioctl_addr(ia0), .ioctl_rd(ir0), .ioctl_din(din0)
  );

  jtframe_pocket_upload #(.RD_LAT(2), .AW(25)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bridge(bif2), .dataslot_done(ds2), .uploading(upl2),
    .ioctl_addr(ia2), .ioctl_rd(ir2), .ioctl_din(din2)
  );

  function automatic logic [7:0] mem_byte(input logic [24:0] a);
    case (a)
      25'h40:  return 8'h11;
      25'h41:  return 8'h22;
      25'h42:  return 8'h33;
      25'h43:  return 8'h44;
      default: return a[7:0] ^ a[15:8] ^ a[23:16] ^ {7'd0, a[24]} ^ 8'hA5;
    endcase
  endfunction

  // Memory model: data valid only exactly RD_LAT cycles after a strobe.
  always @(posedge clk) begin
    hv[0] <= ir2;
    ha[0] <= ia2;
    hv[1] <= hv[0];
    ha[1] <= ha[0];
  end
  assign din0 = ir0   ? mem_byte(ia0)   : 8'hEE;
  assign din2 = hv[1] ? mem_byte(ha[1]) : 8'hEE;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_s(input int i, input exp_t e);
    if (i == 0) sq0.push_back(e); else sq1.push_back(e);
  endtask

  task automatic push_v(input int i, input int c, input logic [31:0] w);
    exp_t e;
    e.cyc = c;
    e.val = w;
    if (i == 0) vq0.push_back(e); else vq1.push_back(e);
  endtask

  task automatic push_fetch(input int i, input int c0, input int lat, input logic [22:0] a,
                            input int nb, input bit v, input logic [31:0] w);
    exp_t e;
    if (strobe_chk) begin
      for (int n = 0; n < nb; n++) begin
        e.cyc = c0 + 1 + n * (lat + 1);
        e.val = {7'd0, a, 2'(n)};
        push_s(i, e);
      end
    end
    if (v) push_v(i, c0 + 4 * (lat + 1) + 1, w);
  endtask

  task automatic mon(input int i, input logic rd, input logic [24:0] a, input logic v, input logic [31:0] d);
    exp_t e;
    int   sz;
    if (strobe_chk && rd) begin
      checks++;
      sz = (i == 0) ? sq0.size() : sq1.size();
      if (sz == 0) begin
        errors++;
        $display("FAIL strobe%0d unexpected at cycle %0d addr %h", i, cyc, a);
      end else begin
        if (i == 0) e = sq0.pop_front(); else e = sq1.pop_front();
        if (e.cyc != cyc || e.val[24:0] != a) begin
          errors++;
          $display("FAIL strobe%0d actual cycle %0d addr %h expected cycle %0d addr %h",
                   i, cyc, a, e.cyc, e.val[24:0]);
        end
      end
    end
    if (v) begin
      checks++;
      sz = (i == 0) ? vq0.size() : vq1.size();
      if (sz == 0) begin
        errors++;
        $display("FAIL rd_valid%0d unexpected at cycle %0d data %h", i, cyc, d);
      end else begin
        if (i == 0) e = vq0.pop_front(); else e = vq1.pop_front();
        if (e.cyc != cyc || e.val != d) begin
          errors++;
          $display("FAIL rd_valid%0d actual cycle %0d data %h expected cycle %0d data %h",
                   i, cyc, d, e.cyc, e.val);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, ir0, ia0, bif0.rd_valid, bif0.bridge_rd_data);
    mon(1, ir2, ia2, bif2.rd_valid, bif2.bridge_rd_data);
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives a one-cycle request; returns one cycle later with c0 = request cycle.
  task automatic start_rd(input int i, input logic [31:0] a, input bit with_ds, output int c0);
    @(posedge clk);
    #1;
    if (i == 0) begin
      bif0.bridge_rd = 1'b1; bif0.bridge_addr = a; ds0 = with_ds;
    end else begin
      bif2.bridge_rd = 1'b1; bif2.bridge_addr = a; ds2 = with_ds;
    end
    c0 = cyc;
    @(posedge clk);
    #1;
    bif0.bridge_rd = 1'b0; bif2.bridge_rd = 1'b0; ds0 = 1'b0; ds2 = 1'b0;
  endtask

  initial begin
    int c0, c1;
`ifdef JTFRAME_POCKET_UPLOAD_PREFETCH_EN
    strobe_chk = 1'b0;
`else
    strobe_chk = 1'b1;
`endif
    rst_n = 1'b0;
    bif0.bridge_rd = 1'b0; bif0.bridge_addr = '0;
    bif2.bridge_rd = 1'b0; bif2.bridge_addr = '0;
    ds0 = 1'b0; ds2 = 1'b0;
    idle(3);
    chk("reset_rd_valid", 32'(bif2.rd_valid), 32'd0);
    chk("reset_rd_busy", 32'(bif2.rd_busy), 32'd0);
    chk("reset_data", bif2.bridge_rd_data, 32'd0);
    chk("reset_ioctl_rd", 32'(ir2), 32'd0);
    chk("reset_ioctl_addr", 32'(ia2), 32'd0);
    chk("reset_uploading", 32'(upl2), 32'd0);
    chk("reset_data0", bif0.bridge_rd_data, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Basic fetch, RD_LAT=2
    start_rd(1, 32'h10, 1'b0, c0);
    push_fetch(1, c0, 2, 23'h10, 4, 1'b1, 32'h44332211);
    chk("uploading_set", 32'(upl2), 32'd1);
    idle(16);
    chk("data_hold", bif2.bridge_rd_data, 32'h44332211);

    // RD_LAT=0 with busy window
    start_rd(0, 32'h0, 1'b0, c0);
    push_fetch(0, c0, 0, 23'h0, 4, 1'b1, 32'hA6A7A4A5);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("busy0_cycle%0d", k), 32'(bif0.rd_busy), (k <= 5) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
    end
    idle(3);

    // Restart in cycle 6 of a fetch
    start_rd(1, 32'h10, 1'b0, c0);
    push_fetch(1, c0, 2, 23'h10, 2, 1'b0, 32'h0);
    idle(4);
    start_rd(1, 32'h20, 1'b0, c1);
    push_fetch(1, c1, 2, 23'h20, 4, 1'b1, 32'h26272425);
    idle(16);

    // Top address, upper request bits ignored
    start_rd(1, 32'hFF7FFFFF, 1'b0, c0);
    push_fetch(1, c0, 2, 23'h7FFFFF, 4, 1'b1, 32'h5B5A5958);
    idle(16);

    // uploading: clear, then set wins over clear; fetch not aborted
    ds2 = 1'b1;
    idle(1);
    ds2 = 1'b0;
    chk("uploading_clear", 32'(upl2), 32'd0);
    chk("uploading0_kept", 32'(upl0), 32'd1);
    start_rd(1, 32'h10, 1'b1, c0);
    push_fetch(1, c0, 2, 23'h10, 4, 1'b1, 32'h44332211);
    chk("uploading_set_wins", 32'(upl2), 32'd1);
    idle(16);

    // Reset in cycle 5 of a fetch
    start_rd(1, 32'h20, 1'b0, c0);
    push_fetch(1, c0, 2, 23'h20, 2, 1'b0, 32'h0);
    idle(4);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rd_valid", 32'(bif2.rd_valid), 32'd0);
    chk("rst_mid_rd_busy", 32'(bif2.rd_busy), 32'd0);
    chk("rst_mid_data", bif2.bridge_rd_data, 32'd0);
    chk("rst_mid_ioctl_addr", 32'(ia2), 32'd0);
    chk("rst_mid_uploading", 32'(upl2), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(20);

`ifdef JTFRAME_POCKET_UPLOAD_PREFETCH_EN
    start_rd(1, 32'h10, 1'b0, c0);
    push_v(1, c0 + 13, 32'h44332211);
    idle(20);
    start_rd(1, 32'h11, 1'b0, c0);
    push_v(1, c0 + 1, 32'hE2E3E0E1);
    idle(20);
    start_rd(1, 32'h30, 1'b0, c0);
    push_v(1, c0 + 13, 32'h66676465);
    idle(20);
`endif

    idle(5);
    chk("leftover_strobe0", sq0.size(), 32'd0);
    chk("leftover_strobe2", sq1.size(), 32'd0);
    chk("leftover_valid0", vq0.size(), 32'd0);
    chk("leftover_valid2", vq1.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
